// File: rtl/pulse_logger_pkg.sv
// Shared definitions for the pulse logger.
// Provides default parameter values, the two FSM state encodings and a record
// type at the default widths (the top builds its own record at its parameters).
package pulse_logger_pkg;

  localparam int unsigned WidthWDefault = 8;
  localparam int unsigned SeqWDefault   = 8;
  localparam int unsigned DepthDefault  = 4;

  // FSM state encodings
  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StHigh = 1'b1;

  typedef struct packed {
    logic [SeqWDefault-1:0]   seq;
    logic [WidthWDefault-1:0] width;
    logic                     sat;
  } pulse_rec_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO for pulse records.
// Ports: clk_i/rst_ni clock and async active-low reset; clr_i empties the FIFO;
// push_i/data_i write a record; pop_i removes the head; head_o is the head record
// (zero when empty); full_o/empty_o give occupancy after the current edge.
// A push while full succeeds only if a pop happens in the same cycle.
module sync_fifo #(
  parameter type         rec_t = logic,
  parameter int unsigned DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic push_i,
  input  rec_t data_i,
  input  logic pop_i,
  output rec_t head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  // One extra pointer bit separates full from empty when the indices match.
  logic [PtrW:0] wr_q, wr_d, rd_q, rd_d;
  rec_t          mem_q [DEPTH];
  logic          do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PtrW] != rd_q[PtrW]) && (wr_q[PtrW-1:0] == rd_q[PtrW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = empty_o ? rec_t'('0) : mem_q[rd_q[PtrW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clr_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) mem_q[wr_q[PtrW-1:0]] <= data_i;
  end

endmodule

// File: rtl/pulse_logger.sv
// Pulse width logger.
// Registers the conditioned level in_i once, measures each high pulse in clock
// cycles (saturating), tags it with a sequence number and queues the record.
// Ports: clk_i, rst_ni (async active-low), in_i level, clr_i sync clear,
// ev_valid_o/ev_ready_i handshake with ev_width_o/ev_sat_o/ev_seq_o record
// fields, drop_cnt_o records lost to a full FIFO, busy_o measuring, full_o FIFO full.
module pulse_logger
  import pulse_logger_pkg::*;
#(
  parameter int unsigned WIDTH_W = WidthWDefault,
  parameter int unsigned SEQ_W   = SeqWDefault,
  parameter int unsigned DEPTH   = DepthDefault
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_i,
  input  logic               clr_i,
  output logic               ev_valid_o,
  input  logic               ev_ready_i,
  output logic [WIDTH_W-1:0] ev_width_o,
  output logic               ev_sat_o,
  output logic [SEQ_W-1:0]   ev_seq_o,
  output logic [SEQ_W-1:0]   drop_cnt_o,
  output logic               busy_o,
  output logic               full_o
);

  typedef struct packed {
    logic [SEQ_W-1:0]   seq;
    logic [WIDTH_W-1:0] width;
    logic               sat;
  } rec_t;

  logic               s_q;
  logic [0:0]         state_q, state_d;
  logic [WIDTH_W-1:0] cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic [SEQ_W-1:0]   drop_q, drop_d;
  logic               push, empty;
  rec_t               rec, head;

  assign rec = '{seq: seq_q, width: cnt_q, sat: sat_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    seq_d   = seq_q;
    drop_d  = drop_q;
    push    = 1'b0;
    if (clr_i) begin
      state_d = StIdle;
      cnt_d   = '0;
      sat_d   = 1'b0;
      seq_d   = '0;
      drop_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (s_q) begin
            state_d = StHigh;
            cnt_d   = WIDTH_W'(1);
            sat_d   = 1'b0;
          end
        end
        default: begin
          if (s_q) begin
            if (cnt_q == '1) sat_d = 1'b1;
            else             cnt_d = cnt_q + 1'b1;
          end else begin
            push    = 1'b1;
            seq_d   = seq_q + 1'b1;
            state_d = StIdle;
            // Full with no pop this cycle: the FIFO refuses the record.
            if (full_o && !ev_ready_i && drop_q != '1) drop_d = drop_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_q     <= 1'b0;
      state_q <= StIdle;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      seq_q   <= '0;
      drop_q  <= '0;
    end else begin
      s_q     <= in_i;  // deliberately untouched by clr_i
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      seq_q   <= seq_d;
      drop_q  <= drop_d;
    end
  end

  sync_fifo #(
    .rec_t (rec_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clr_i),
    .push_i  (push),
    .data_i  (rec),
    .pop_i   (ev_ready_i),
    .head_o  (head),
    .full_o  (full_o),
    .empty_o (empty)
  );

  assign ev_valid_o = !empty;
  assign ev_width_o = head.width;
  assign ev_sat_o   = head.sat;
  assign ev_seq_o   = head.seq;
  assign drop_cnt_o = drop_q;
  assign busy_o     = (state_q == StHigh);

endmodule

// File: tb/tb_pulse_logger.sv
module tb_pulse_logger;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_s;
  logic       clr;
  logic       ev_ready;
  logic       ev_valid;
  logic [3:0] ev_width;
  logic       ev_sat;
  logic [7:0] ev_seq;
  logic [7:0] drop_cnt;
  logic       busy;
  logic       full;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pulse_logger #(
    .WIDTH_W (4),
    .SEQ_W   (8),
    .DEPTH   (4)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_i       (in_s),
    .clr_i      (clr),
    .ev_valid_o (ev_valid),
    .ev_ready_i (ev_ready),
    .ev_width_o (ev_width),
    .ev_sat_o   (ev_sat),
    .ev_seq_o   (ev_seq),
    .drop_cnt_o (drop_cnt),
    .busy_o     (busy),
    .full_o     (full)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges; return 1 ns after the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    in_s = 1'b1;
    tick(hi);
    in_s = 1'b0;
    tick(lo);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_s = 1'b0; clr = 1'b0; ev_ready = 1'b0;
    tick(2);
    chk("rst_valid", ev_valid, 0);
    chk("rst_width", ev_width, 0);
    chk("rst_sat", ev_sat, 0);
    chk("rst_seq", ev_seq, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    rst_n = 1'b1;
    tick(1);

    // Single 3-edge pulse
    ev_ready = 1'b1;
    in_s = 1'b1;
    tick(1);
    chk("single_busy_e1", busy, 0);
    tick(1);
    chk("single_busy_e2", busy, 1);
    tick(1);
    in_s = 1'b0;
    tick(1);
    chk("single_busy_e4", busy, 1);
    chk("single_nvalid_e4", ev_valid, 0);
    tick(1);
    chk("single_valid", ev_valid, 1);
    chk("single_width", ev_width, 3);
    chk("single_seq", ev_seq, 0);
    chk("single_sat", ev_sat, 0);
    chk("single_busy_end", busy, 0);
    tick(1);
    chk("single_popped", ev_valid, 0);

    // Saturation at WIDTH_W=4
    in_s = 1'b1;
    tick(20);
    in_s = 1'b0;
    tick(2);
    chk("sat_valid", ev_valid, 1);
    chk("sat_width", ev_width, 15);
    chk("sat_sat", ev_sat, 1);
    chk("sat_seq", ev_seq, 1);
    tick(1);
    chk("sat_popped", ev_valid, 0);

    // Back-pressure and drop
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    ev_ready = 1'b0;
    for (int i = 0; i < 6; i++) pulse(1, 1);
    tick(2);
    chk("bp_full", full, 1);
    chk("bp_drop", drop_cnt, 2);
    chk("bp_valid", ev_valid, 1);
    chk("bp_head0", ev_seq, 0);
    chk("bp_width", ev_width, 1);
    ev_ready = 1'b1;
    tick(1);
    chk("bp_head1", ev_seq, 1);
    chk("bp_notfull", full, 0);
    tick(1);
    chk("bp_head2", ev_seq, 2);
    tick(1);
    chk("bp_head3", ev_seq, 3);
    tick(1);
    chk("bp_empty", ev_valid, 0);
    in_s = 1'b1;
    tick(1);
    in_s = 1'b0;
    tick(2);
    chk("bp_seventh_valid", ev_valid, 1);
    chk("bp_seventh_seq", ev_seq, 6);
    tick(1);
    chk("bp_seventh_popped", ev_valid, 0);

    // Full push+pop in the same cycle: seqs 7..10 fill, 11 arrives with a pop
    ev_ready = 1'b0;
    for (int i = 0; i < 4; i++) pulse(1, 1);
    tick(1);
    chk("pp_full_before", full, 1);
    chk("pp_head_before", ev_seq, 7);
    in_s = 1'b1;
    tick(1);
    in_s = 1'b0;
    tick(1);
    ev_ready = 1'b1;
    tick(1);
    chk("pp_drop", drop_cnt, 2);
    chk("pp_full_after", full, 1);
    chk("pp_head_after", ev_seq, 8);
    tick(3);
    chk("pp_last_seq", ev_seq, 11);
    tick(1);
    chk("pp_drained", ev_valid, 0);

    // clr during a 10-edge pulse, with a stale record queued
    ev_ready = 1'b0;
    pulse(2, 2);
    chk("clr_pre_valid", ev_valid, 1);
    in_s = 1'b1;
    tick(4);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clr_empty", ev_valid, 0);
    chk("clr_busy", busy, 0);
    chk("clr_drop", drop_cnt, 0);
    chk("clr_full", full, 0);
    tick(5);
    in_s = 1'b0;
    tick(2);
    chk("clr_rec_valid", ev_valid, 1);
    chk("clr_rec_width", ev_width, 6);
    chk("clr_rec_seq", ev_seq, 0);
    chk("clr_rec_sat", ev_sat, 0);
    ev_ready = 1'b1;
    tick(1);
    chk("clr_popped", ev_valid, 0);

    // Async reset mid-pulse with a record queued
    ev_ready = 1'b0;
    pulse(1, 2);
    chk("rstm_pre_valid", ev_valid, 1);
    in_s = 1'b1;
    tick(4);
    chk("rstm_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rstm_valid", ev_valid, 0);
    chk("rstm_busy", busy, 0);
    chk("rstm_seq", ev_seq, 0);
    chk("rstm_width", ev_width, 0);
    chk("rstm_full", full, 0);
    in_s = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(4);
    chk("rstm_no_record", ev_valid, 0);

    // Sub-cycle glitches are never sampled
    in_s = 1'b1;
    #1;
    in_s = 1'b0;
    tick(1);
    chk("glitch1_busy", busy, 0);
    in_s = 1'b1;
    #4;
    in_s = 1'b0;
    tick(1);
    chk("glitch2_busy_a", busy, 0);
    tick(2);
    chk("glitch2_busy_b", busy, 0);
    chk("glitch_no_record", ev_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
